// File: rtl/axi_lite_reg_arbiter.sv
// rtl/axi_lite_reg_arbiter.sv - round-robin arbiter of two register requesters onto one AXI-Lite master
// Optional response timeout is enabled by defining ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module axi_lite_reg_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wvalid,
  output logic                  m_wlast,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  output logic                  m_rready
);
  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE} state_t;

  state_t                r_state;
  logic                  r_last_grant, r_grant;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata0, r_rdata1;
  logic                  r_done0, r_done1, r_err0, r_err1;

  logic                  w_any, w_pick, w_sel_write, w_aw_pending, w_w_pending;
  logic                  w_fin, w_fin_err, w_expired;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata, w_fin_data;

  // On a tie the requester not granted last wins; a lone requester always wins.
  assign w_any        = req0_valid | req1_valid;
  assign w_pick       = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_sel_write  = w_pick ? req1_write : req0_write;
  assign w_sel_addr   = w_pick ? req1_addr  : req0_addr;
  assign w_sel_wdata  = w_pick ? req1_wdata : req0_wdata;
  assign w_aw_pending = r_awvalid & ~m_awready;
  assign w_w_pending  = r_wvalid  & ~m_wready;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_expired = (r_state == S_WR_RESP || r_state == S_RD_RESP) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset)
      r_cnt <= '0;
    else if ((r_state == S_WR_RESP || r_state == S_RD_RESP) && !w_fin)
      r_cnt <= r_cnt + CNT_W'(1);
    else
      r_cnt <= '0;
  end
`else
  // Without the timeout a response is awaited forever; the parameter stays for a uniform interface.
  assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_fin      = 1'b0;
    w_fin_err  = 1'b0;
    w_fin_data = '0;
    if (r_state == S_WR_RESP && m_bvalid)
      w_fin = 1'b1;
    if (r_state == S_RD_RESP && m_rvalid) begin
      w_fin      = 1'b1;
      w_fin_data = m_rdata;
    end
    if (!w_fin && w_expired) begin
      w_fin     = 1'b1;
      w_fin_err = 1'b1;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      r_wdata      <= '0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_grant      <= w_pick;
          r_last_grant <= w_pick;
          if (w_sel_write) begin
            r_awaddr  <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_WR_REQ;
          end else begin
            r_araddr  <= w_sel_addr;
            r_arvalid <= 1'b1;
            r_state   <= S_RD_REQ;
          end
        end
        S_WR_REQ: begin
          r_awvalid <= w_aw_pending;
          r_wvalid  <= w_w_pending;
          if (!w_aw_pending && !w_w_pending) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_RD_REQ: if (m_arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= S_RD_RESP;
        end
        S_WR_RESP, S_RD_RESP: if (w_fin) begin
          r_bready <= 1'b0;
          r_rready <= 1'b0;
          r_done0  <= ~r_grant;
          r_done1  <= r_grant;
          r_rdata0 <= r_grant ? '0 : w_fin_data;
          r_rdata1 <= r_grant ? w_fin_data : '0;
          r_err0   <= ~r_grant & w_fin_err;
          r_err1   <= r_grant & w_fin_err;
          r_state  <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_awaddr   = r_awaddr;
  assign m_awvalid  = r_awvalid;
  assign m_wdata    = r_wdata;
  assign m_wvalid   = r_wvalid;
  assign m_wlast    = r_wvalid;
  assign m_bready   = r_bready;
  assign m_araddr   = r_araddr;
  assign m_arvalid  = r_arvalid;
  assign m_rready   = r_rready;
  assign req0_done  = r_done0;
  assign req1_done  = r_done1;
  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;
  assign req0_err   = r_err0;
  assign req1_err   = r_err1;
endmodule

// File: doc/axi_lite_reg_arbiter.md
AXI_LITE_REG_ARBITER -- requirements
Module: axi_lite_reg_arbiter

Interface
REQ-001 ADDR_WIDTH, default 32, byte-address width of requester and AXI address ports.
REQ-002 DATA_WIDTH, default 32, data width of requester and AXI data ports.
REQ-003 TIMEOUT_CYCLES, default 255, response-wait limit in cycles (used only when ARB_TIMEOUT_EN is defined).
REQ-004 axi_aclk  input  1  sole clock; all logic is rising-edge.
REQ-005 axi_reset  input  1  asynchronous, active-high reset.
REQ-006 reqN_valid (N=0,1)  input  1  requester N wants one register access; held high until reqN_done.
REQ-007 reqN_write  input  1  1=write, 0=read; stable while reqN_valid.
REQ-008 reqN_addr  input  ADDR_WIDTH  register byte address; stable while reqN_valid.
REQ-009 reqN_wdata  input  DATA_WIDTH  write data; stable while reqN_valid.
REQ-010 reqN_done  output  1  one-cycle pulse: access N complete.
REQ-011 reqN_rdata  output  DATA_WIDTH  read data, valid with reqN_done.
REQ-012 reqN_err  output  1  qualifies reqN_done: access aborted by timeout.
REQ-013 m_awaddr  output  ADDR_WIDTH  write address.
REQ-014 m_awvalid  output  1  write address valid.
REQ-015 m_awready  input  1  write address accepted.
REQ-016 m_wdata  output  DATA_WIDTH  write data.
REQ-017 m_wvalid  output  1  write data valid.
REQ-018 m_wlast  output  1  always equal to m_wvalid (single-beat).
REQ-019 m_wready  input  1  write data accepted.
REQ-020 m_bvalid  input  1  write response valid.
REQ-021 m_bready  output  1  write response ready.
REQ-022 m_araddr  output  ADDR_WIDTH  read address.
REQ-023 m_arvalid  output  1  read address valid.
REQ-024 m_arready  input  1  read address accepted.
REQ-025 m_rdata  input  DATA_WIDTH  read data.
REQ-026 m_rvalid  input  1  read data valid.
REQ-027 m_rready  output  1  read data ready.

Function
REQ-028 FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; exactly one access in flight.
REQ-029 IDLE: if any reqN_valid, grant, latch write/addr/wdata of winner, go to WR_REQ or RD_REQ next cycle.
REQ-030 Arbitration round-robin: single requester always wins; both valid -> the one not granted last; last_grant updates on each grant.
REQ-031 WR_REQ: m_awvalid and m_wvalid asserted in the same cycle (never AW after W); each drops independently once its ready is sampled high; both accepted -> WR_RESP.
REQ-032 WR_RESP: m_bready held high; m_bvalid&m_bready -> DONE.
REQ-033 RD_REQ: m_arvalid high until m_arready -> RD_RESP; RD_RESP: m_rready held high, m_rvalid -> capture m_rdata, DONE.
REQ-034 DONE: one-cycle reqN_done for granted N only, with reqN_rdata (0 for writes) and reqN_err; then IDLE; requester deasserted in the same cycle as done is never re-granted.
REQ-035 Minimum latency grant-to-done: write 4 cycles, read 4 cycles with zero-wait slave.
REQ-036 bresp/rresp ignored; rlast ignored.
REQ-037 reqN_valid dropped mid-access: access still completes, done still pulses.

Reset
REQ-038 While axi_reset: state IDLE, all valid/ready/done/err outputs 0, addr/data outputs 0, last_grant=1 (req0 wins first tie), timeout counter 0.
REQ-039 Reset mid-access abandons it with no done pulse; AXI valids drop asynchronously.

Configuration
REQ-040 ARB_TIMEOUT_EN defined: counter counts in WR_RESP/RD_RESP, reaching TIMEOUT_CYCLES -> DONE with reqN_err=1, rdata=0, counter cleared on entry to each state.
REQ-041 ARB_TIMEOUT_EN undefined: no counter, reqN_err tied 0, response waits indefinitely.

Verification
REQ-042 req0 write addr 0x08 data 0x0000_00FF, zero-wait slave -> AW+W same cycle with 0x08/0xFF, req0_done after 4 cycles, err=0.
REQ-043 req1 read addr 0x2C, slave returns 0x1234_5678 -> req1_done with req1_rdata=0x1234_5678, req0_done stays 0.
REQ-044 Both valid continuously after reset -> grant order 0,1,0,1 for four accesses.
REQ-045 m_wready delayed 3 cycles after m_awready -> m_awvalid drops after 1 cycle, m_wvalid held 4 cycles, one B handshake.
REQ-046 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, m_rvalid never asserted -> done with err=1, rdata=0 after 16 RD_RESP cycles; undefined -> no done.
REQ-047 axi_reset asserted in WR_RESP -> all outputs 0 immediately, no done, next request served normally.
